sd_cmd_engine: RTL and testbench

Hardware SD-card SPI command sequencer that sits between the register block and the byte-wide SPI shifter path. On a start pulse it sends a preamble byte and the 6-byte SD command frame, generating CRC7 itself. It then polls for the R1 response within a bounded window and optionally collects a 4-byte trailer (R3/R7). While busy it owns the shifter byte stream; the top level muxes the shifter between CPU FIFO traffic and this engine using `eng_active`.

---
 rtl/sd_pkg.sv | 17 +
 rtl/sd_crc7.sv | 23 ++
 rtl/sd_cmd_engine.sv | 201 ++++++++++++++++++++
 tb/tb_sd_cmd_engine.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_pkg.sv
// rtl/sd_pkg.sv - shared states and frame constants for the SD command engine
package sd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_RX,
    ST_DRAIN,
    ST_DONE
  } sd_state_e;

  localparam logic [6:0] SD_CRC7_POLY     = 7'h09;
  localparam logic [7:0] SD_FILL_BYTE     = 8'hFF;
  localparam int         SD_FRAME_LAST    = 6;
  localparam int         SD_TRAILER_BYTES = 4;

endpackage

// File: rtl/sd_crc7.sv
// rtl/sd_crc7.sv - one-byte CRC7 (x^7+x^3+1) update, MSB first
module sd_crc7
  import sd_pkg::*;
(
  input  logic [6:0] crc_in,
  input  logic [7:0] data_in,
  output logic [6:0] crc_out
);

  // Clock all eight bits of the byte through the LFSR in one combinational step
  always_comb begin
    logic [6:0] c;
    logic       fb;
    c  = crc_in;
    fb = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      fb = data_in[i] ^ c[6];
      c  = {c[5:0], 1'b0} ^ (fb ? SD_CRC7_POLY : 7'h00);
    end
    crc_out = c;
  end

endmodule

// File: rtl/sd_cmd_engine.sv
// rtl/sd_cmd_engine.sv - SD SPI command sequencer: frame send, R1 poll, optional trailer
module sd_cmd_engine
  import sd_pkg::*;
#(
  parameter int unsigned POLL_MAX = 8
) (
  input  logic        C100M,
  input  logic        RESET_n,
  input  logic        start,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] cmd_arg,
  input  logic        resp_ext,
  input  logic        abort,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        eng_active,
  output logic        done,
  output logic        timeout,
  output logic        aborted,
  output logic [7:0]  r1,
  output logic [31:0] resp
);

  localparam logic [7:0] POLL_LAST  = 8'(POLL_MAX - 1);
  localparam logic [2:0] TRL_LAST   = 3'(SD_TRAILER_BYTES - 1);
  localparam logic [2:0] FRAME_LAST = 3'(SD_FRAME_LAST);

  sd_state_e   state, state_nxt;
  logic [5:0]  idx_q;
  logic [31:0] arg_q;
  logic        ext_q;
  logic [2:0]  bcnt;     // frame byte index, parks at 7 once the frame is out
  logic [7:0]  pcnt;     // poll bytes seen without an R1
  logic [2:0]  tcnt;     // trailer bytes collected
  logic        r1_seen;
  logic [6:0]  crc_q, crc_nxt;
  logic        tx_hs, rx_hs;
  logic        ld_cmd, bcnt_inc, poll_inc, r1_ld, trl_ld, set_to, set_ab;

  assign tx_hs = tx_valid && tx_ready;
  assign rx_hs = rx_valid && rx_ready;

  sd_crc7 u_crc7 (
    .crc_in  (crc_q),
    .data_in (tx_data),
    .crc_out (crc_nxt)
  );

  function automatic logic [7:0] frame_byte(input logic [2:0] n);
    case (n)
      3'd1:    frame_byte = {2'b01, idx_q};
      3'd2:    frame_byte = arg_q[31:24];
      3'd3:    frame_byte = arg_q[23:16];
      3'd4:    frame_byte = arg_q[15:8];
      3'd5:    frame_byte = arg_q[7:0];
      3'd6:    frame_byte = {crc_q, 1'b1};
      default: frame_byte = SD_FILL_BYTE;
    endcase
  endfunction

  // State register
  always_ff @(posedge C100M or negedge RESET_n) begin
    if (!RESET_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Next state and one-cycle action strobes for the datapath
  always_comb begin
    state_nxt = state;
    ld_cmd    = 1'b0;
    bcnt_inc  = 1'b0;
    poll_inc  = 1'b0;
    r1_ld     = 1'b0;
    trl_ld    = 1'b0;
    set_to    = 1'b0;
    set_ab    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          ld_cmd    = 1'b1;
          state_nxt = ST_SEND;
        end
      end
      ST_SEND: begin
        // A byte accepted together with abort still owes us one rx byte
        if (tx_hs) begin
          state_nxt = abort ? ST_DRAIN : ST_WAIT_RX;
        end else if (abort) begin
          set_ab    = 1'b1;
          state_nxt = ST_DONE;
        end
      end
      ST_WAIT_RX: begin
        if (abort) begin
          if (rx_hs) begin
            set_ab    = 1'b1;
            state_nxt = ST_DONE;
          end else begin
            state_nxt = ST_DRAIN;
          end
        end else if (rx_hs) begin
          if (bcnt <= FRAME_LAST) begin
            bcnt_inc  = 1'b1;
            state_nxt = ST_SEND;
          end else if (!r1_seen) begin
            if (!rx_data[7]) begin
              r1_ld     = 1'b1;
              state_nxt = ext_q ? ST_SEND : ST_DONE;
            end else if (pcnt == POLL_LAST) begin
              set_to    = 1'b1;
              state_nxt = ST_DONE;
            end else begin
              poll_inc  = 1'b1;
              state_nxt = ST_SEND;
            end
          end else begin
            trl_ld    = 1'b1;
            state_nxt = (tcnt == TRL_LAST) ? ST_DONE : ST_SEND;
          end
        end
      end
      ST_DRAIN: begin
        if (rx_hs) begin
          set_ab    = 1'b1;
          state_nxt = ST_DONE;
        end
      end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Registered handshake outputs, command latches, counters, CRC and results
  always_ff @(posedge C100M or negedge RESET_n) begin
    if (!RESET_n) begin
      tx_valid   <= 1'b0;
      tx_data    <= SD_FILL_BYTE;
      rx_ready   <= 1'b0;
      eng_active <= 1'b0;
      done       <= 1'b0;
      timeout    <= 1'b0;
      aborted    <= 1'b0;
      r1         <= SD_FILL_BYTE;
      resp       <= 32'h0;
      idx_q      <= 6'h0;
      arg_q      <= 32'h0;
      ext_q      <= 1'b0;
      bcnt       <= 3'd0;
      pcnt       <= 8'd0;
      tcnt       <= 3'd0;
      r1_seen    <= 1'b0;
      crc_q      <= 7'h0;
    end else begin
      tx_valid   <= (state_nxt == ST_SEND);
      rx_ready   <= (state_nxt == ST_WAIT_RX) || (state_nxt == ST_DRAIN);
      eng_active <= (state_nxt != ST_IDLE);
      done       <= (state_nxt == ST_DONE);

      if (ld_cmd) begin
        idx_q   <= cmd_index;
        arg_q   <= cmd_arg;
        ext_q   <= resp_ext;
        timeout <= 1'b0;
        aborted <= 1'b0;
        r1      <= SD_FILL_BYTE;
        resp    <= 32'h0;
        bcnt    <= 3'd0;
        pcnt    <= 8'd0;
        tcnt    <= 3'd0;
        r1_seen <= 1'b0;
        crc_q   <= 7'h0;
        tx_data <= SD_FILL_BYTE;
      end else if ((state == ST_WAIT_RX) && (state_nxt == ST_SEND)) begin
        tx_data <= bcnt_inc ? frame_byte(bcnt + 3'd1) : SD_FILL_BYTE;
      end

      // Only the index and argument bytes feed the CRC
      if ((state == ST_SEND) && tx_hs && (bcnt >= 3'd1) && (bcnt <= 3'd5)) begin
        crc_q <= crc_nxt;
      end

      if (bcnt_inc) bcnt <= bcnt + 3'd1;
      if (poll_inc) pcnt <= pcnt + 8'd1;
      if (r1_ld) begin
        r1      <= rx_data;
        r1_seen <= 1'b1;
      end
      if (trl_ld) begin
        resp <= {resp[23:0], rx_data};
        tcnt <= tcnt + 3'd1;
      end
      if (set_to) timeout <= 1'b1;
      if (set_ab) aborted <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sd_cmd_engine.sv
// tb/tb_sd_cmd_engine.sv - self-checking bench for sd_cmd_engine
`timescale 1ns/1ps
module tb_sd_cmd_engine;

  localparam int POLL_MAX = 8;

  logic        C100M = 1'b0;
  logic        RESET_n = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  cmd_index = 6'h0;
  logic [31:0] cmd_arg = 32'h0;
  logic        resp_ext = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        eng_active;
  logic        done;
  logic        timeout;
  logic        aborted;
  logic [7:0]  r1;
  logic [31:0] resp;

  sd_cmd_engine #(.POLL_MAX(POLL_MAX)) dut (
    .C100M      (C100M),
    .RESET_n    (RESET_n),
    .start      (start),
    .cmd_index  (cmd_index),
    .cmd_arg    (cmd_arg),
    .resp_ext   (resp_ext),
    .abort      (abort),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .eng_active (eng_active),
    .done       (done),
    .timeout    (timeout),
    .aborted    (aborted),
    .r1         (r1),
    .resp       (resp)
  );

  always #5 C100M = ~C100M;

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Model state: scripted card replies and the outcome they must produce
  logic [7:0]  rx_script [64];
  logic [7:0]  exp_tx [64];
  int          exp_n_tx, exp_n_rx;
  logic [7:0]  exp_r1;
  logic [31:0] exp_resp;
  logic        exp_to, exp_ab;

  // CRC7 as polynomial long division of msg * x^7 by x^7+x^3+1
  function automatic logic [6:0] crc7_ref(input logic [39:0] msg);
    logic [46:0] r;
    r = {msg, 7'b0};
    for (int i = 46; i >= 7; i--)
      if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    return r[6:0];
  endfunction

  task automatic build_model(input logic [5:0] idx, input logic [31:0] arg, input bit ext);
    int n;
    bit found;
    logic [7:0] b;
    for (int i = 0; i < 64; i++) exp_tx[i] = 8'hFF;
    exp_tx[0] = 8'hFF;
    exp_tx[1] = {2'b01, idx};
    exp_tx[2] = arg[31:24];
    exp_tx[3] = arg[23:16];
    exp_tx[4] = arg[15:8];
    exp_tx[5] = arg[7:0];
    exp_tx[6] = {crc7_ref({2'b01, idx, arg}), 1'b1};
    n = 7;
    found = 0;
    exp_r1 = 8'hFF;
    exp_resp = 32'h0;
    exp_to = 0;
    exp_ab = 0;
    for (int p = 0; p < POLL_MAX && !found; p++) begin
      b = rx_script[n];
      n++;
      if (!b[7]) begin
        found = 1;
        exp_r1 = b;
      end
    end
    if (!found) exp_to = 1;
    else if (ext) begin
      for (int t = 0; t < 4; t++) begin
        exp_resp = {exp_resp[23:0], rx_script[n]};
        n++;
      end
    end
    exp_n_tx = n;
    exp_n_rx = n;
  endtask

  // Responder: one rx byte per accepted tx byte, optional random stalls
  bit         stall_en = 0;
  int         hold_tx_idx = -1;
  int         hold_rx_idx = -1;
  int         k = 0;
  int         pend_idx = 0;
  bit         pend = 0;
  logic [7:0] pend_byte = 8'hFF;

  initial begin : responder
    bit txh, rxh;
    forever begin
      @(negedge C100M);
      txh = tx_valid && tx_ready;
      rxh = rx_valid && rx_ready;
      @(posedge C100M);
      #1;
      if (!RESET_n) pend = 0;
      else begin
        if (rxh) pend = 0;
        if (txh) begin
          pend = 1;
          pend_idx = k;
          pend_byte = (k < 64) ? rx_script[k] : 8'hFF;
          k++;
        end
      end
      tx_ready = (k != hold_tx_idx) && (!stall_en || $urandom_range(0, 2) != 0);
      rx_valid = pend && (pend_idx != hold_rx_idx) && (!stall_en || $urandom_range(0, 2) != 0);
      rx_data  = rx_valid ? pend_byte : 8'h00;
    end
  end

  // Compare process: tx byte order/value every valid cycle, results on done
  bit chk_en = 0;
  int txn = 0, rxn = 0, ndone = 0;

  always @(negedge C100M) begin
    if (RESET_n && chk_en) begin
      if (tx_valid) begin
        check("tx_byte", 32'(tx_data), 32'(exp_tx[txn % 64]));
        if (tx_ready) begin
          if (txn >= exp_n_tx) check("tx_extra", 32'(txn + 1), 32'(exp_n_tx));
          txn++;
        end
      end
      if (rx_valid && rx_ready) rxn++;
      if (done) begin
        ndone++;
        check("done_r1", 32'(r1), 32'(exp_r1));
        check("done_resp", resp, exp_resp);
        check("done_timeout", 32'(timeout), 32'(exp_to));
        check("done_aborted", 32'(aborted), 32'(exp_ab));
        check("done_tx_count", 32'(txn), 32'(exp_n_tx));
        check("done_rx_count", 32'(rxn), 32'(exp_n_rx));
      end
    end
  end

  task automatic step();
    @(posedge C100M);
    #3;
  endtask

  task automatic check_reset_vals(input string p);
    check({p, "_tx_valid"}, 32'(tx_valid), 32'h0);
    check({p, "_tx_data"}, 32'(tx_data), 32'hFF);
    check({p, "_rx_ready"}, 32'(rx_ready), 32'h0);
    check({p, "_eng_active"}, 32'(eng_active), 32'h0);
    check({p, "_done"}, 32'(done), 32'h0);
    check({p, "_timeout"}, 32'(timeout), 32'h0);
    check({p, "_aborted"}, 32'(aborted), 32'h0);
    check({p, "_r1"}, 32'(r1), 32'hFF);
    check({p, "_resp"}, resp, 32'h0);
  endtask

  task automatic script_ff();
    for (int i = 0; i < 64; i++) rx_script[i] = 8'hFF;
  endtask

  task automatic start_cmd(input logic [5:0] idx, input logic [31:0] arg, input bit ext, output int base);
    txn = 0;
    rxn = 0;
    k = 0;
    pend = 0;
    base = ndone;
    cmd_index = idx;
    cmd_arg = arg;
    resp_ext = ext;
    start = 1;
    step();
    start = 0;
    check("start_eng_active", 32'(eng_active), 32'h1);
    check("start_tx_valid", 32'(tx_valid), 32'h1);
  endtask

  task automatic finish_cmd(input int base);
    for (int i = 0; i < 3000 && ndone == base; i++) step();
    check("done_seen", 32'(ndone != base), 32'h1);
    repeat (3) step();
    check("done_pulses", 32'(ndone - base), 32'h1);
    check("idle_after_done", 32'(eng_active), 32'h0);
  endtask

  task automatic wait_txn(input int target, input string name);
    int i;
    for (i = 0; i < 2000 && txn < target; i++) step();
    check(name, 32'(txn >= target), 32'h1);
  endtask

  task automatic run_cmd0();
    int base;
    script_ff();
    rx_script[8] = 8'h01;
    build_model(6'd0, 32'h0, 1'b0);
    check("model_cmd0_crc", 32'(exp_tx[6]), 32'h95);
    start_cmd(6'd0, 32'h0, 1'b0, base);
    finish_cmd(base);
    check("cmd0_r1", 32'(r1), 32'h01);
    check("cmd0_timeout", 32'(timeout), 32'h0);
  endtask

  task automatic run_cmd8();
    int base;
    script_ff();
    rx_script[7] = 8'h01;
    rx_script[8] = 8'h00;
    rx_script[9] = 8'h00;
    rx_script[10] = 8'h01;
    rx_script[11] = 8'hAA;
    build_model(6'd8, 32'h000001AA, 1'b1);
    check("model_cmd8_crc", 32'(exp_tx[6]), 32'h87);
    start_cmd(6'd8, 32'h000001AA, 1'b1, base);
    finish_cmd(base);
    check("cmd8_r1", 32'(r1), 32'h01);
    check("cmd8_resp", resp, 32'h000001AA);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

  initial begin : main
    int base;
    script_ff();
    build_model(6'd0, 32'h0, 1'b0);
    repeat (3) @(posedge C100M);
    #3;
    check_reset_vals("reset");
    RESET_n = 1;
    step();
    chk_en = 1;

    run_cmd0();
    run_cmd8();

    // Timeout: card never answers
    script_ff();
    build_model(6'd17, 32'h12345678, 1'b0);
    check("model_timeout_len", 32'(exp_n_tx), 32'd15);
    start_cmd(6'd17, 32'h12345678, 1'b0, base);
    finish_cmd(base);
    check("to_timeout", 32'(timeout), 32'h1);
    check("to_r1", 32'(r1), 32'hFF);

    // Backpressure on both streams must not change the result
    stall_en = 1;
    run_cmd8();
    run_cmd0();
    stall_en = 0;

    // Abort while waiting for the rx of byte 3
    script_ff();
    rx_script[8] = 8'h01;
    build_model(6'd0, 32'h0, 1'b0);
    exp_n_tx = 4;
    exp_n_rx = 4;
    exp_ab = 1;
    exp_r1 = 8'hFF;
    exp_to = 0;
    exp_resp = 32'h0;
    hold_rx_idx = 3;
    start_cmd(6'd0, 32'h0, 1'b0, base);
    wait_txn(4, "ab_rx_reach_byte3");
    step();
    check("ab_rx_waiting", 32'(rx_ready), 32'h1);
    abort = 1;
    step();
    abort = 0;
    hold_rx_idx = -1;
    finish_cmd(base);
    check("ab_rx_aborted", 32'(aborted), 32'h1);

    // Abort while byte 2 is stalled in SEND
    build_model(6'd0, 32'h0, 1'b0);
    exp_n_tx = 2;
    exp_n_rx = 2;
    exp_ab = 1;
    exp_r1 = 8'hFF;
    exp_to = 0;
    exp_resp = 32'h0;
    hold_tx_idx = 2;
    start_cmd(6'd0, 32'h0, 1'b0, base);
    wait_txn(2, "ab_send_reach_byte2");
    repeat (3) step();
    check("ab_send_tx_valid", 32'(tx_valid), 32'h1);
    abort = 1;
    step();
    abort = 0;
    hold_tx_idx = -1;
    finish_cmd(base);
    check("ab_send_aborted", 32'(aborted), 32'h1);

    // Start while busy is ignored
    script_ff();
    rx_script[8] = 8'h01;
    build_model(6'd0, 32'h0, 1'b0);
    start_cmd(6'd0, 32'h0, 1'b0, base);
    repeat (5) step();
    cmd_index = 6'd8;
    cmd_arg = 32'hDEADBEEF;
    resp_ext = 1;
    start = 1;
    step();
    start = 0;
    finish_cmd(base);
    check("busy_start_r1", 32'(r1), 32'h01);

    // Abort in IDLE is ignored
    base = ndone;
    abort = 1;
    step();
    abort = 0;
    repeat (2) step();
    check("idle_abort_flag", 32'(aborted), 32'h0);
    check("idle_abort_active", 32'(eng_active), 32'h0);
    check("idle_abort_done", 32'(ndone - base), 32'h0);

    // Asynchronous reset in the poll phase, then a clean CMD0
    script_ff();
    build_model(6'd0, 32'h0, 1'b0);
    start_cmd(6'd0, 32'h0, 1'b0, base);
    wait_txn(9, "rst_reach_poll");
    chk_en = 0;
    @(negedge C100M);
    #2;
    RESET_n = 0;
    #1;
    check_reset_vals("async_rst");
    step();
    step();
    RESET_n = 1;
    step();
    chk_en = 1;
    run_cmd0();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
